// File: rtl/wide_mul_seq.sv
// wide_mul_seq: forms an unsigned (8*LIMBS)x(8*LIMBS) product by streaming
// limb pairs through one external registered 8x8 multiplier. Each returning
// 16-bit partial product is added into a 2W accumulator at byte offset i+j.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). A sampled
// start latches op_a/op_b. done pulses for exactly one cycle, and that is the
// same cycle in which result first shows the new product. result holds
// between done pulses.
module wide_mul_seq #(
  parameter int LIMBS   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8*LIMBS-1:0]   op_a,
  input  logic [8*LIMBS-1:0]   op_b,
  output logic                 busy,
  output logic                 done,
  output logic [16*LIMBS-1:0]  result,
  output logic [7:0]           mul_d,
  output logic [7:0]           mul_e,
  input  logic [15:0]          mul_f
);

  localparam int W  = 8 * LIMBS;
  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam int KW = $clog2(2 * LIMBS) > 0 ? $clog2(2 * LIMBS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic [7:0]           mul_d_q, mul_d_d, mul_e_q, mul_e_d;
  logic [2*W-1:0]       acc_q, acc_d, result_q, result_d;
  logic                 busy_q, busy_d, done_q, done_d;

  // Tag travelling with the issued pair. The last flag marks the final pair,
  // so that DRAIN knows which product completes the operation.
  logic                 iss_vld_q, iss_vld_d, iss_last_q, iss_last_d;
  logic [KW-1:0]        iss_k_q, iss_k_d;
  logic [MUL_LAT-1:0]   pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [KW-1:0]        pipe_k_q [MUL_LAT];
  logic [KW-1:0]        pipe_k_d [MUL_LAT];

  logic                 out_vld, out_last;
  logic [2*W-1:0]       prod_sh, acc_sum;
  logic [IW-1:0]        ni, nj;
  logic                 last_pair;

  // Align the emerging tag with mul_f and form the shifted partial sum.
  always_comb begin
    out_vld   = pipe_vld_q[MUL_LAT-1];
    out_last  = pipe_last_q[MUL_LAT-1];
    prod_sh   = {{(2*W-16){1'b0}}, mul_f} << {pipe_k_q[MUL_LAT-1], 3'b000};
    acc_sum   = acc_q + prod_sh;
    last_pair = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  end

  // Next-state, counter, issue and accumulate logic.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    i_d        = i_q;
    j_d        = j_q;
    ni         = '0;
    nj         = '0;
    mul_d_d    = 8'd0;
    mul_e_d    = 8'd0;
    iss_vld_d  = 1'b0;
    iss_last_d = 1'b0;
    iss_k_d    = '0;
    acc_d      = out_vld ? acc_sum : acc_q;
    result_d   = result_q;
    done_d     = 1'b0;

    pipe_vld_d[0]  = iss_vld_q;
    pipe_last_d[0] = iss_last_q;
    pipe_k_d[0]    = iss_k_q;
    for (int s = 1; s < MUL_LAT; s++) begin
      pipe_vld_d[s]  = pipe_vld_q[s-1];
      pipe_last_d[s] = pipe_last_q[s-1];
      pipe_k_d[s]    = pipe_k_q[s-1];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d    = S_ISSUE;
          a_d        = op_a;
          b_d        = op_b;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          mul_d_d    = op_a[7:0];
          mul_e_d    = op_b[7:0];
          iss_vld_d  = 1'b1;
          iss_last_d = (LIMBS == 1);
          iss_k_d    = '0;
        end
      end
      S_ISSUE: begin
        if (last_pair) begin
          state_d = S_DRAIN;
        end else begin
          if (j_q == LAST_IDX) begin
            ni = i_q + 1'b1;
            nj = '0;
          end else begin
            ni = i_q;
            nj = j_q + 1'b1;
          end
          i_d        = ni;
          j_d        = nj;
          mul_d_d    = a_q[8*ni +: 8];
          mul_e_d    = b_q[8*nj +: 8];
          iss_vld_d  = 1'b1;
          iss_last_d = (ni == LAST_IDX) && (nj == LAST_IDX);
          iss_k_d    = KW'(ni) + KW'(nj);
        end
      end
      S_DRAIN: begin
        if (out_vld && out_last) begin
          state_d  = S_DONE;
          result_d = acc_sum;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
  end

  // State and datapath registers; async reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      mul_d_q     <= 8'd0;
      mul_e_q     <= 8'd0;
      iss_vld_q   <= 1'b0;
      iss_last_q  <= 1'b0;
      iss_k_q     <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int s = 0; s < MUL_LAT; s++) pipe_k_q[s] <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      j_q         <= j_d;
      mul_d_q     <= mul_d_d;
      mul_e_q     <= mul_e_d;
      iss_vld_q   <= iss_vld_d;
      iss_last_q  <= iss_last_d;
      iss_k_q     <= iss_k_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      for (int s = 0; s < MUL_LAT; s++) pipe_k_q[s] <= pipe_k_d[s];
      acc_q       <= acc_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_d  = mul_d_q;
  assign mul_e  = mul_e_q;

endmodule

// File: tb/tb_wide_mul_seq.sv
// tb_wide_mul_seq: drives wide_mul_seq with directed and random operands.
// A registered 8x8 multiplier model stands in for the external primitive.
// Products are checked against plain 64-bit multiplication.
module tb_wide_mul_seq;

  localparam int LIMBS   = 4;
  localparam int MUL_LAT = 2;
  localparam int W       = 8 * LIMBS;
  localparam int DONE_CYC = LIMBS * LIMBS + MUL_LAT + 1;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [W-1:0]    op_a  = '0;
  logic [W-1:0]    op_b  = '0;
  logic            busy, done;
  logic [2*W-1:0]  result;
  logic [7:0]      mul_d, mul_e;
  logic [15:0]     mul_f;

  // external multiplier: input register then output register
  logic [7:0]      m_d_q = 8'd0, m_e_q = 8'd0;
  logic [15:0]     m_f_q = 16'd0;

  int              total = 0;
  int              bad   = 0;
  logic [2*W-1:0]  prev_result = '0;
  logic [2*W-1:0]  exp_q[$];

  wide_mul_seq #(.LIMBS(LIMBS), .MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .mul_d  (mul_d),
    .mul_e  (mul_e),
    .mul_f  (mul_f)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_d_q <= mul_d;
    m_e_q <= mul_e;
    m_f_q <= m_d_q * m_e_q;
  end
  assign mul_f = m_f_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents start with operands, then follows the
  // operation cycle by cycle. Returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit ignore_pulses);
    logic [2*W-1:0] exp;
    bit seen;
    int li, lj;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        exp  = exp_q.pop_front();
        check("done_cycle", 64'(c), 64'(DONE_CYC));
        check("result", result, exp);
        check("busy_at_done", 64'(busy), 64'd0);
        check("mul_d_at_done", 64'(mul_d), 64'd0);
        check("mul_e_at_done", 64'(mul_e), 64'd0);
        prev_result = exp;
      end else begin
        check("busy", 64'(busy), 64'd1);
        check("result_hold", result, prev_result);
        if (c <= LIMBS * LIMBS) begin
          li = (c - 1) / LIMBS;
          lj = (c - 1) % LIMBS;
          check("mul_d", 64'(mul_d), 64'(a[8*li +: 8]));
          check("mul_e", 64'(mul_e), 64'(b[8*lj +: 8]));
        end else begin
          check("mul_d_drain", 64'(mul_d), 64'd0);
          check("mul_e_drain", 64'(mul_e), 64'd0);
        end
        if (ignore_pulses) begin
          op_a  = $urandom;
          op_b  = $urandom;
          start = (c == 5 || c == 12);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
  endtask

  // Called one cycle after a done that was not chained.
  task automatic idle_check();
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_result", result, prev_result);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_mul_d", 64'(mul_d), 64'd0);
    check("rst_mul_e", 64'(mul_e), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk); idle_check();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk); idle_check();
    run_op(32'h0000_00FF, 32'h0000_FF00, 1'b0);
    @(negedge clk); idle_check();
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0);
    @(negedge clk); idle_check();

    // back-to-back: second start presented in the done cycle
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0005, 1'b0);
    @(negedge clk); idle_check();

    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 3 == 1) ra = ra & {4{8'($urandom_range(0, 255))}};
      if (n % 3 == 2) rb = rb >> $urandom_range(0, 31);
      run_op(ra, rb, n[0]);
      @(negedge clk); idle_check();
    end

    // reset in cycle 10 of an operation
    op_a  = 32'hCAFE_F00D;
    op_b  = 32'h1357_9BDF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_mul_d", 64'(mul_d), 64'd0);
    check("midrst_mul_e", 64'(mul_e), 64'd0);
    prev_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      check("post_rst_no_done", 64'(done), 64'd0);
    end
    idle_check();
    run_op(32'hCAFE_F00D, 32'h1357_9BDF, 1'b0);
    @(negedge clk); idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wide_mul_seq.md
Name: wide_mul_seq

Overview:
- Sequencer that computes an unsigned (8*LIMBS)x(8*LIMBS) product using one shared registered 8x8 unsigned multiplier.
- Each cycle it issues one 8-bit limb pair to the multiplier and accumulates the returning 16-bit products at the correct byte offset.
- It sits between the modular-multiplication datapath (requester) and the multiplier primitive, which is instantiated outside this block and wired to the mul_* ports.

Parameters:
- LIMBS, 4, number of 8-bit limbs per operand; operand width W = 8*LIMBS.
- MUL_LAT, 2, cycles from driving mul_d/mul_e to the matching product on mul_f (input register plus output register).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op_a  in  W  multiplicand; latched when start is accepted.
- op_b  in  W  multiplier; latched when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result is updated.
- result  out  2W  product; holds its value until the next done.
- mul_d  out  8  limb of A to the multiplier.
- mul_e  out  8  limb of B to the multiplier.
- mul_f  in  16  multiplier product, MUL_LAT cycles after issue.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; busy=0, done=0, result=0, mul_d=0, mul_e=0.
  - Accumulator, counters and the tag pipeline clear.
  - Reset mid-operation abandons the operation; no done is produced.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE / DONE:
  - start=1 at a rising edge latches op_a and op_b, clears the accumulator and moves to ISSUE.
  - DONE always leaves after one cycle, to ISSUE if start is accepted, else to IDLE.
  - Back-to-back operations are allowed: start in the done cycle is accepted.
- ISSUE, LIMBS*LIMBS cycles:
  - Counters i (A limb, outer) and j (B limb, inner) run 0..LIMBS-1.
  - mul_d = A[8i+7:8i], mul_e = B[8j+7:8j], both registered so they are valid for the whole issue cycle.
  - Issue order: (0,0),(0,1)..(0,L-1),(1,0)..(L-1,L-1).
  - On the last pair, move to DRAIN.
- Tag pipeline, MUL_LAT deep: carries {valid, shift k=i+j} alongside each issue.
  - When a valid tag emerges, acc <= acc + (mul_f << 8k).
  - Addition is 2W bits wide and never overflows, because the full product fits in 2W bits.
- DRAIN:
  - mul_d and mul_e are driven to 0.
  - Stays until the last valid tag has been accumulated.
  - At that edge, result <= final accumulator value and the state goes to DONE.
- Timing:
  - busy=1 in ISSUE and DRAIN, 0 in IDLE and DONE; done=1 only in DONE.
  - Start accepted at edge 0 gives busy=1 from cycle 1, and done plus the new result in cycle LIMBS^2+MUL_LAT+1 (cycle 19 at defaults).
- Outside ISSUE, mul_d and mul_e are 0.
- start while busy=1 is ignored; op_a and op_b changes while busy have no effect.
- result is stable between done pulses; a new operation does not disturb it until its own done.

Test Plan:
- Reset, then start with op_a=0x00000001, op_b=0xDEADBEEF -> busy rises next cycle; done in cycle 19; result=0x00000000DEADBEEF.
- op_a=op_b=0xFFFFFFFF -> result=0xFFFFFFFE00000001, exercising carry propagation across every byte offset.
- op_a=0x000000FF, op_b=0x0000FF00 -> result=0x0000000000FE0100. Also op_a=op_b=0x00010000 -> result=0x0000000100000000, checking shift placement.
- Pulse start again in cycles 5 and 12 with different operands -> ignored; result matches the first operands; exactly one done.
- Start accepted in the done cycle with op_a=3, op_b=5 -> first result unchanged until the second done 19 cycles later; result=0x000000000000000F.
- Deassert rst_n in cycle 10 of an operation -> busy, done, result, mul_d and mul_e go to 0 immediately with no done; a fresh start after release gives the correct product.
